dmem_wb_slave: RTL and testbench
================================

Name: dmem_wb_slave

Overview:
Data-memory responder at the far end of the load/store path. It accepts byte-lane-selected word transfers from the core's load/store unit over a Wishbone B4 classic slave port and stores data in an internal byte-writable RAM. It returns full aligned words on reads and acknowledges after a programmable number of wait states. Lane extraction and sign extension stay on the core side; this block only honours byte selects on writes.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
WAIT_STATES, 1, extra cycles inserted before ack (0..15).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^ADDR_WIDTH.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, synchronous, active-high.
wbs_addr_i  in  32  byte address; bits [1:0] ignored.
wbs_dat_i  in  32  write data, already lane-replicated by the master.
wbs_sel_i  in  4  byte-lane enables; bit n covers dat[8n+7:8n].
wbs_we_i  in  1  1 = write, 0 = read.
wbs_cyc_i  in  1  bus cycle active.
wbs_stb_i  in  1  transfer strobe.
wbs_dat_o  out  32  read data; valid only while ack is high.
wbs_ack_o  out  1  transfer complete; one-cycle pulse.
wbs_err_o  out  1  transfer error; one-cycle pulse, used only with the optional feature.

Behaviour:
- Reset: state IDLE, wait counter 0, ack_o=0, err_o=0, dat_o=0. RAM contents are not reset.
- Word index is (addr_i - BASE_ADDR)[ADDR_WIDTH+1:2].
- FSM states IDLE, WAIT, RESP:
  - IDLE: when cyc&stb is high in cycle N, latch addr, dat, sel and we. Issue the RAM read address. Load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: decrement the counter each cycle. At 1, go to RESP. If cyc drops, go to IDLE with no write and no ack.
  - RESP: assert ack_o (or err_o) for exactly this cycle and return to IDLE.
    - Writes commit to RAM on the RESP clock edge, for lanes with sel=1 only.
    - Reads drive dat_o with the full word, regardless of sel.
    - If cyc is low in RESP, suppress the ack and the write.
- Latency: ack is high in cycle N+1+WAIT_STATES. Minimum is 1 because the RAM read is synchronous.
- Back-to-back: after RESP the FSM spends one cycle in IDLE. If stb is still high in that cycle, a new transfer is latched, so throughput is at most 1 transfer per 2+WAIT_STATES cycles.
- Address, data and sel changes after latching are ignored until the next IDLE.
- dat_o returns to 0 in every cycle without ack. ack and err are never high together.
- A write with sel=4'b0000 is acked and leaves the RAM unchanged.
- Read-after-write to the same word returns the new data, because the write commits before the next transfer is latched.
- rst_i asserted mid-transfer: go to IDLE next edge, outputs to reset values, pending write discarded.

Optional Feature:
DMEM_RANGE_CHECK_EN
- Defined: a transfer whose addr_i lies outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WIDTH) responds with err_o instead of ack_o, with identical timing. No write occurs and dat_o=0.
- Undefined: no range check. The address aliases modulo the depth, err_o is tied to 0, and every transfer is acked.

Decomposition:
- Package dmem_pkg:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Default ADDR_WIDTH and WAIT_STATES.
  - Wishbone data and sel widths.
- Sub-module dmem_ram_be:
  - Single-port synchronous RAM, 32-bit words, 4 byte write enables, 1-cycle read latency.
  - Instantiated once; read-during-write returns old data, which the FSM never exposes.

Test Plan:
- Reset: hold rst_i 2 cycles with cyc=stb=1 -> ack=0, err=0, dat_o=0 throughout. First ack comes 1+WAIT_STATES cycles after rst_i falls.
- Word write then read, WAIT_STATES=1: write 32'hDEADBEEF, sel=4'hF to 0x10; read 0x10 -> ack in cycle N+2 with dat_o=32'hDEADBEEF.
- Byte and halfword lanes:
  - Write 32'h11223344 to 0x20, then addr=0x22, sel=4'b0100, dat=32'hAAAAAAAA -> read 0x20 returns 32'h11AA3344.
  - Then sel=4'b0011, dat=32'h55665566 -> read returns 32'h11AA5566.
- Abort: write 32'hCAFEF00D to 0x30, drop cyc during WAIT (WAIT_STATES=3) -> no ack. Subsequent read of 0x30 returns the old value.
- WAIT_STATES=0 back-to-back, stb held high for 4 transfers -> ack on every second cycle, correct data on each ack.
- With DMEM_RANGE_CHECK_EN, ADDR_WIDTH=10: read 0x0000_1000 -> err_o pulses, ack_o=0, dat_o=0. Without the macro, the same read aliases to word 0 and is acked.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory Wishbone slave.
package dmem_pkg;
  localparam int DMEM_AW_DEF = 10;
  localparam int DMEM_WS_DEF = 1;
  localparam int WB_DAT_W    = 32;
  localparam int WB_SEL_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/dmem_ram_be.sv
// Single-port synchronous RAM with per-byte write enables and one-cycle registered read.
module dmem_ram_be
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_AW_DEF
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [WB_SEL_W-1:0]   be_i,
  input  logic [WB_DAT_W-1:0]   wdat_i,
  output logic [WB_DAT_W-1:0]   rdat_o
);
  logic [WB_DAT_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [WB_DAT_W-1:0] rdat_q;

  // Read-during-write returns the old word; the slave never reads and writes in one cycle.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdat_q <= mem_q[addr_i];
    end
    if (we_i) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdat_i[8*b +: 8];
        end
      end
    end
  end

  assign rdat_o = rdat_q;
endmodule

// File: rtl/dmem_wb_slave.sv
// Wishbone B4 classic data-memory slave: byte-lane writes, full-word reads, WAIT_STATES extra cycles before ack.
// Optional DMEM_RANGE_CHECK_EN: addresses outside the window answer with err_o instead of ack_o.
module dmem_wb_slave
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = DMEM_AW_DEF,
  parameter int          WAIT_STATES = DMEM_WS_DEF,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         wbs_addr_i,
  input  logic [WB_DAT_W-1:0] wbs_dat_i,
  input  logic [WB_SEL_W-1:0] wbs_sel_i,
  input  logic                wbs_we_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  output logic [WB_DAT_W-1:0] wbs_dat_o,
  output logic                wbs_ack_o,
  output logic                wbs_err_o
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  dmem_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [WB_DAT_W-1:0]   wdat_q, wdat_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  oor_q, oor_d;

  logic [31:0]           off;
  logic                  req;
  logic                  oor_in;
  logic                  resp_live;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_re;
  logic                  ram_we;
  logic [WB_DAT_W-1:0]   ram_rdat;
  logic                  unused_off;

  assign off        = wbs_addr_i - BASE_ADDR;
  assign req        = wbs_cyc_i & wbs_stb_i;
  assign unused_off = ^off;

`ifdef DMEM_RANGE_CHECK_EN
  // Unsigned wrap makes addresses below BASE_ADDR land far above the window too.
  assign oor_in = |(off >> (ADDR_WIDTH + 2));
`else
  assign oor_in = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    oor_d   = oor_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = off[ADDR_WIDTH+1:2];
          wdat_d  = wbs_dat_i;
          sel_d   = wbs_sel_i;
          we_d    = wbs_we_i;
          oor_d   = oor_in;
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The read address is issued straight from the bus in IDLE so data is ready one edge later.
  assign ram_addr  = (state_q == IDLE) ? off[ADDR_WIDTH+1:2] : idx_q;
  assign ram_re    = (state_q == IDLE) & req & ~rst_i;
  assign resp_live = (state_q == RESP) & wbs_cyc_i & ~rst_i;
  assign ram_we    = resp_live & we_q & ~oor_q;

  assign wbs_ack_o = resp_live & ~oor_q;
  assign wbs_err_o = resp_live & oor_q;
  assign wbs_dat_o = (wbs_ack_o & ~we_q) ? ram_rdat : '0;

  dmem_ram_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clk_i),
    .addr_i (ram_addr),
    .re_i   (ram_re),
    .we_i   (ram_we),
    .be_i   (sel_q),
    .wdat_i (wdat_q),
    .rdat_o (ram_rdat)
  );
endmodule

// File: tb/tb_dmem_wb_slave.sv
// Bench for dmem_wb_slave: three instances (WAIT_STATES 1, 0, 3) against a word-array memory model.
module tb_dmem_wb_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0][31:0] addr_v;
  logic [2:0][31:0] wdat_v;
  logic [2:0][3:0]  sel_v;
  logic [2:0]       we_v;
  logic [2:0]       cyc_v;
  logic [2:0]       stb_v;
  wire  [2:0][31:0] rdat_v;
  wire  [2:0]       ack_v;
  wire  [2:0]       err_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_wb_slave #(
      .ADDR_WIDTH  (10),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .BASE_ADDR   (32'h0000_0000)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wbs_addr_i (addr_v[g]),
      .wbs_dat_i  (wdat_v[g]),
      .wbs_sel_i  (sel_v[g]),
      .wbs_we_i   (we_v[g]),
      .wbs_cyc_i  (cyc_v[g]),
      .wbs_stb_i  (stb_v[g]),
      .wbs_dat_o  (rdat_v[g]),
      .wbs_ack_o  (ack_v[g]),
      .wbs_err_o  (err_v[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [3][1024];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // Memory model: word index wraps modulo depth; sel picks which bytes change.
  function automatic void mwrite(input int k, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
    int w;
    logic [31:0] m;
    w = int'((a >> 2) % 1024);
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    mdl[k][w] = (mdl[k][w] & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] mread(input int k, input logic [31:0] a);
    return mdl[k][int'((a >> 2) % 1024)];
  endfunction

  // Called just after a rising edge; returns just after the edge following the response.
  task automatic xfer(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic [31:0] rd, output int lat,
                      output logic a_seen, output logic e_seen);
    addr_v[k] = a; wdat_v[k] = d; sel_v[k] = s; we_v[k] = w;
    cyc_v[k] = 1'b1; stb_v[k] = 1'b1;
    lat = 0; a_seen = 1'b0; e_seen = 1'b0; rd = '0;
    while (!a_seen && !e_seen && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      a_seen = ack_v[k]; e_seen = err_v[k]; rd = rdat_v[k];
    end
    @(posedge clk); #1;
    cyc_v[k] = 1'b0; stb_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    int first [3];
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr_v[k] = '0; wdat_v[k] = '0; sel_v[k] = 4'hF; we_v[k] = 1'b0;
      cyc_v[k] = 1'b1; stb_v[k] = 1'b1; first[k] = 0;
    end
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({ack_v[k], err_v[k], rdat_v[k]} !== 34'd0)
          $display("FAIL reset_outputs[%0d]: ack=%b err=%b dat=%h want all 0", k, ack_v[k], err_v[k], rdat_v[k]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (first[k] == 0 && ack_v[k] === 1'b1) first[k] = c;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (first[k] !== 1 + ws_of(k)) begin
        errors++;
        $display("FAIL first_ack_latency[%0d]: got %0d want %0d", k, first[k], 1 + ws_of(k));
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin cyc_v[k] = 1'b0; stb_v[k] = 1'b0; end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; int lat; logic a, e;
    xfer(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, lat, a, e);
    mwrite(0, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if (a !== 1'b1 || e !== 1'b0 || lat != 2) begin
      errors++; $display("FAIL word_write: ack=%b err=%b lat=%0d want ack=1 err=0 lat=2", a, e, lat);
    end
    xfer(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, a, e);
    checks++;
    if (a !== 1'b1 || lat != 2 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_read: ack=%b lat=%0d dat=%h want 1/2/deadbeef", a, lat, rd);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; int lat; logic a, e;
    xfer(0, 32'h20, 32'h11223344, 4'hF, 1'b1, rd, lat, a, e);
    mwrite(0, 32'h20, 32'h11223344, 4'hF);
    xfer(0, 32'h22, 32'hAAAAAAAA, 4'b0100, 1'b1, rd, lat, a, e);
    mwrite(0, 32'h22, 32'hAAAAAAAA, 4'b0100);
    xfer(0, 32'h20, 32'h0, 4'h0, 1'b0, rd, lat, a, e);
    checks++;
    if (a !== 1'b1 || rd !== 32'h11AA3344) begin
      errors++; $display("FAIL byte_lane: ack=%b dat=%h want 11aa3344", a, rd);
    end
    xfer(0, 32'h20, 32'h55665566, 4'b0011, 1'b1, rd, lat, a, e);
    mwrite(0, 32'h20, 32'h55665566, 4'b0011);
    xfer(0, 32'h20, 32'h0, 4'h0, 1'b0, rd, lat, a, e);
    checks++;
    if (a !== 1'b1 || rd !== 32'h11AA5566) begin
      errors++; $display("FAIL half_lane: ack=%b dat=%h want 11aa5566", a, rd);
    end
    xfer(0, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1, rd, lat, a, e);
    xfer(0, 32'h20, 32'h0, 4'h0, 1'b0, rd, lat, a, e);
    checks++;
    if (a !== 1'b1 || rd !== 32'h11AA5566) begin
      errors++; $display("FAIL sel_zero_write: ack=%b dat=%h want 11aa5566", a, rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat; logic a, e; logic seen;
    xfer(2, 32'h30, 32'h01234567, 4'hF, 1'b1, rd, lat, a, e);
    mwrite(2, 32'h30, 32'h01234567, 4'hF);
    checks++;
    if (a !== 1'b1 || lat != 4) begin
      errors++; $display("FAIL abort_setup: ack=%b lat=%0d want 1/4", a, lat);
    end
    addr_v[2] = 32'h30; wdat_v[2] = 32'hCAFEF00D; sel_v[2] = 4'hF; we_v[2] = 1'b1;
    cyc_v[2] = 1'b1; stb_v[2] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    cyc_v[2] = 1'b0; stb_v[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen = seen | ack_v[2] | err_v[2]; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_ack: saw response=%b want 0", seen);
    end
    @(posedge clk); #1;
    xfer(2, 32'h30, 32'h0, 4'h0, 1'b0, rd, lat, a, e);
    checks++;
    if (a !== 1'b1 || lat != 4 || rd !== 32'h01234567) begin
      errors++; $display("FAIL abort_old_data: ack=%b lat=%0d dat=%h want 1/4/01234567", a, lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, exp;
    for (int t = 0; t < 8; t++) begin
      a = 32'h40 + 32'(4 * (t % 4));
      d = $urandom;
      addr_v[1] = a; wdat_v[1] = d; sel_v[1] = 4'hF; we_v[1] = (t < 4);
      cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
      if (t < 4) mwrite(1, a, d, 4'hF);
      exp = mread(1, a);
      @(negedge clk);
      checks++;
      if (ack_v[1] !== 1'b0 || rdat_v[1] !== 32'h0) begin
        errors++; $display("FAIL b2b_idle_gap[%0d]: ack=%b dat=%h want 0/0", t, ack_v[1], rdat_v[1]);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (ack_v[1] !== 1'b1 || (t >= 4 && rdat_v[1] !== exp)) begin
        errors++; $display("FAIL b2b_ack[%0d]: ack=%b dat=%h want 1/%h", t, ack_v[1], rdat_v[1], exp);
      end
      @(posedge clk); #1;
    end
    cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp; logic [3:0] s; logic w; int lat; logic ak, er;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        a = 32'h100 + 32'(4 * i); d = $urandom;
        xfer(k, a, d, 4'hF, 1'b1, rd, lat, ak, er);
        mwrite(k, a, d, 4'hF);
      end
      for (int n = 0; n < 30; n++) begin
        a = 32'h100 + 32'(4 * $urandom_range(15)) + 32'($urandom_range(3));
        d = $urandom; s = 4'($urandom); w = 1'($urandom);
        exp = mread(k, a);
        xfer(k, a, d, s, w, rd, lat, ak, er);
        if (w) mwrite(k, a, d, s);
        checks++;
        if (ak !== 1'b1 || er !== 1'b0 || lat != 1 + ws_of(k) || (!w && rd !== exp)) begin
          errors++;
          $display("FAIL random[%0d.%0d]: we=%b ack=%b err=%b lat=%0d dat=%h want ack=1 lat=%0d dat=%h",
                   k, n, w, ak, er, lat, rd, 1 + ws_of(k), exp);
        end
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; int lat; logic a, e;
    xfer(0, 32'h0, 32'h5A5A0001, 4'hF, 1'b1, rd, lat, a, e);
    mwrite(0, 32'h0, 32'h5A5A0001, 4'hF);
    xfer(0, 32'h0000_1000, 32'h0, 4'hF, 1'b0, rd, lat, a, e);
`ifdef DMEM_RANGE_CHECK_EN
    checks++;
    if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0 || lat != 2) begin
      errors++; $display("FAIL range_read_err: err=%b ack=%b dat=%h lat=%0d want 1/0/0/2", e, a, rd, lat);
    end
    xfer(0, 32'h0000_1000, 32'hFFFFFFFF, 4'hF, 1'b1, rd, lat, a, e);
    xfer(0, 32'h0, 32'h0, 4'h0, 1'b0, rd, lat, a, e);
    checks++;
    if (a !== 1'b1 || rd !== mread(0, 32'h0)) begin
      errors++; $display("FAIL range_no_write: ack=%b dat=%h want 1/%h", a, rd, mread(0, 32'h0));
    end
`else
    checks++;
    if (a !== 1'b1 || e !== 1'b0 || lat != 2 || rd !== mread(0, 32'h1000)) begin
      errors++; $display("FAIL range_alias: ack=%b err=%b lat=%0d dat=%h want 1/0/2/%h",
                         a, e, lat, rd, mread(0, 32'h1000));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_abort();
    test_back_to_back();
    test_random();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
